// File: rtl/fifo_rd_drain.sv
// -----------------------------------------------------------------------------
// fifo_rd_drain
//
// Read-side drain stage for an asynchronous FIFO, r_clk domain. It pops words
// whenever the FIFO is non-empty and there is room downstream. A 2-entry skid
// buffer absorbs the FIFO's one-cycle read latency. Words are presented on a
// valid/ready stream in their original order, at up to one word per cycle.
//
// Handshake: a word moves from the stream port to the consumer in every cycle
// where m_valid and m_ready are both high. While m_valid is high and m_ready is
// low, m_data is held stable. m_valid never depends on m_ready.
//
// Optional feature macro: FIFO_RD_STATS_EN
//   defined   -> pop_count / stall_count are live statistics counters
//   undefined -> both ports are tied to zero and no counter flops exist
//
// Parameters
//   DATASIZE      width of a FIFO word and of the stream data
//
// Ports
//   r_clk         read-domain clock, rising edge
//   r_rst         asynchronous active-low reset
//   r_empty       FIFO empty flag
//   r_en          FIFO pop request (one word per high cycle)
//   r_data        FIFO read data, valid the cycle after r_en
//   flush         synchronous discard of buffered and in-flight words
//   m_valid       stream word available
//   m_ready       consumer accepts
//   m_data        stream data (head of the skid buffer)
//   busy          buffer non-empty or a read in flight
//   pop_count     words popped (wraps)
//   stall_count   cycles with m_valid && !m_ready (saturates)
//   dbg_occ       skid-buffer occupancy state (EMPTY/ONE/TWO)
//   dbg_inflight  registered copy of the previous cycle's r_en
// -----------------------------------------------------------------------------
module fifo_rd_drain #(
    parameter int DATASIZE = 8
) (
    input  logic                r_clk,
    input  logic                r_rst,
    input  logic                r_empty,
    output logic                r_en,
    input  logic [DATASIZE-1:0] r_data,
    input  logic                flush,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATASIZE-1:0] m_data,
    output logic                busy,
    output logic [15:0]         pop_count,
    output logic [15:0]         stall_count,
    output logic [1:0]          dbg_occ,
    output logic                dbg_inflight
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e                state_q, state_d;
    logic                inflight_q, inflight_d;
    // head_q is always the oldest word and drives m_data directly.
    logic [DATASIZE-1:0] head_q, head_d;
    logic [DATASIZE-1:0] tail_q, tail_d;

    logic xfer;
    logic cap;
    logic room;

    // -------------------------------------------------------------------------
    // Stream outputs and pop request
    // -------------------------------------------------------------------------
    always_comb begin
        m_valid = (state_q != EMPTY) && !flush;
        xfer    = m_valid && m_ready;
        // A word returned during a flush cycle is dropped, not captured.
        cap     = inflight_q && !flush;
        // room means occ + inflight < 2.
        room    = (state_q == EMPTY) || ((state_q == ONE) && !inflight_q);
        // When a transfer frees a slot this cycle, a pop can still issue, so a
        // full buffer keeps streaming at one word per cycle. r_rst gates the pop
        // so that no word leaves the FIFO while this stage is held in reset.
        r_en    = r_rst && !r_empty && !flush && (room || xfer);
        busy    = (state_q != EMPTY) || inflight_q;
        m_data  = head_q;
    end

    // -------------------------------------------------------------------------
    // Skid-buffer next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = r_en;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (cap) begin
                        head_d  = r_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    case ({cap, xfer})
                        2'b11: head_d = r_data;      // replace the departing head
                        2'b01: state_d = EMPTY;
                        2'b10: begin
                            tail_d  = r_data;
                            state_d = TWO;
                        end
                        default: ;
                    endcase
                end
                TWO: begin
                    // TWO with a capture but no transfer cannot happen: the pop
                    // is suppressed once occ + inflight reaches 2.
                    if (xfer) begin
                        head_d = tail_q;
                        if (cap) begin
                            tail_d = r_data;
                        end else begin
                            state_d = ONE;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            state_q    <= EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign dbg_occ      = state_q;
    assign dbg_inflight = inflight_q;

    // -------------------------------------------------------------------------
    // Statistics counters (cleared by reset only; flush leaves them alone)
    // -------------------------------------------------------------------------
`ifdef FIFO_RD_STATS_EN
    logic [15:0] pop_cnt_q, pop_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        pop_cnt_d   = pop_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (r_en) begin
            pop_cnt_d = pop_cnt_q + 16'd1;
        end
        if (m_valid && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            pop_cnt_q   <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            pop_cnt_q   <= pop_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pop_count   = pop_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign pop_count   = 16'h0000;
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
module tb_fifo_rd_drain;

    localparam int W = 8;
`ifdef FIFO_RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic         r_clk;
    logic         r_rst;
    logic         r_empty;
    logic         r_en;
    logic [W-1:0] r_data;
    logic         flush;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         busy;
    logic [15:0]  pop_count;
    logic [15:0]  stall_count;
    logic [1:0]   dbg_occ;
    logic         dbg_inflight;

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    fifo_rd_drain #(.DATASIZE(W)) dut (
        .r_clk        (r_clk),
        .r_rst        (r_rst),
        .r_empty      (r_empty),
        .r_en         (r_en),
        .r_data       (r_data),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .busy         (busy),
        .pop_count    (pop_count),
        .stall_count  (stall_count),
        .dbg_occ      (dbg_occ),
        .dbg_inflight (dbg_inflight)
    );

    // ---------------- FIFO model and scoreboard ----------------
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int underflow_cnt = 0;

    typedef struct {
        logic         m_ready;
        logic         flush;
        logic         exp_r_en;
        logic         exp_m_valid;
        logic         exp_busy;
        logic [W-1:0] exp_m_data;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(first + W'(i));
            exp_q.push_back(first + W'(i));
        end
        r_empty = (fifo_q.size() == 0);
    endtask

    // One clock cycle; inputs are already driven, called shortly after a posedge.
    task automatic tick();
        logic         en_s;
        logic         xfer_s;
        logic [W-1:0] data_s;
        logic [W-1:0] e;
        #1;
        en_s   = r_en;
        xfer_s = m_valid && m_ready;
        data_s = m_data;
        if (en_s && r_empty) underflow_cnt++;
        if (xfer_s) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got %0h expected none at %0t", data_s, $time);
            end else begin
                e = exp_q.pop_front();
                chk("stream_data", 32'(data_s), 32'(e));
            end
        end
        @(posedge r_clk);
        #1;
        if (en_s && fifo_q.size() != 0) r_data = fifo_q.pop_front();
        r_empty = (fifo_q.size() == 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_complete", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        // first-word table: 16 words preloaded, m_ready held high
        for (int i = 0; i < 19; i++) begin
            tbl[i].m_ready     = 1'b1;
            tbl[i].flush       = 1'b0;
            tbl[i].exp_r_en    = (i <= 15);
            tbl[i].exp_m_valid = (i >= 2) && (i <= 17);
            tbl[i].exp_busy    = (i >= 1) && (i <= 17);
            tbl[i].exp_m_data  = W'(i - 1);
        end

        r_rst   = 1'b0;
        r_empty = 1'b0;   // non-empty during reset: pop must still be suppressed
        r_data  = '0;
        flush   = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge r_clk);
        #1;
        chk("rst_r_en",    32'(r_en),        32'd0);
        chk("rst_m_valid", 32'(m_valid),     32'd0);
        chk("rst_m_data",  32'(m_data),      32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_pop",     32'(pop_count),   32'd0);
        chk("rst_stall",   32'(stall_count), 32'd0);
        r_empty = 1'b1;
        r_rst   = 1'b1;
        tick();

        // ---- first word latency and full-rate streaming ----
        preload(8'h01, 16);
        for (int i = 0; i < 19; i++) begin
            m_ready = tbl[i].m_ready;
            flush   = tbl[i].flush;
            #1;
            chk("tbl_r_en",    32'(r_en),    32'(tbl[i].exp_r_en));
            chk("tbl_m_valid", 32'(m_valid), 32'(tbl[i].exp_m_valid));
            chk("tbl_busy",    32'(busy),    32'(tbl[i].exp_busy));
            if (tbl[i].exp_m_valid) chk("tbl_m_data", 32'(m_data), 32'(tbl[i].exp_m_data));
            tick();
        end
        chk("s1_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("s1_pop_count",   32'(pop_count),   STATS ? 32'd16 : 32'd0);
        chk("s1_stall_count", 32'(stall_count), 32'd0);

        // ---- backpressure: 10 cycles with m_ready low ----
        preload(8'h21, 8);
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i >= 2) begin
                chk("bp_m_valid", 32'(m_valid), 32'd1);
                chk("bp_m_data",  32'(m_data),  32'h21);
            end
            tick();
        end
        chk("bp_pops",     32'(8 - fifo_q.size()), 32'd2);
        chk("bp_occ",      32'(dbg_occ),      32'd2);
        chk("bp_inflight", 32'(dbg_inflight), 32'd0);
        chk("bp_r_en",     32'(r_en),         32'd0);
        chk("bp_stall_count", 32'(stall_count), STATS ? 32'd8 : 32'd0);
        chk("bp_pop_count",   32'(pop_count),   STATS ? 32'd18 : 32'd0);
        drain(60);
        chk("bp_pop_after_release", 32'(pop_count), STATS ? 32'd24 : 32'd0);

        // ---- m_ready toggling over 32 words ----
        preload(8'h40, 32);
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 300) begin
                m_ready = n[0];
                tick();
                n++;
            end
        end
        chk("toggle_all_delivered", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b1;
        tick();
        tick();
        chk("toggle_pop_count", 32'(pop_count), STATS ? 32'd56 : 32'd0);

        // ---- flush with occ = 2, inflight = 0 ----
        preload(8'h60, 6);
        m_ready = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk("fl_pre_occ",      32'(dbg_occ),      32'd2);
        chk("fl_pre_inflight", 32'(dbg_inflight), 32'd0);
        chk("fl_pre_m_data",   32'(m_data),       32'h60);
        flush = 1'b1;
        #1;
        chk("fl_m_valid", 32'(m_valid), 32'd0);
        chk("fl_r_en",    32'(r_en),    32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_post_m_valid", 32'(m_valid), 32'd0);
        chk("fl_post_busy",    32'(busy),    32'd0);
        exp_q = fifo_q;   // words already popped are gone
        drain(40);

        // ---- reset mid-stream with occ = 1 ----
        preload(8'h70, 8);
        exp_q = fifo_q;
        m_ready = 1'b1;
        tick();
        tick();
        #1;
        chk("mr_pre_m_valid", 32'(m_valid), 32'd1);
        chk("mr_pre_m_data",  32'(m_data),  32'h70);
        chk("mr_pre_occ",     32'(dbg_occ), 32'd1);
        r_rst = 1'b0;
        #1;
        chk("mr_m_valid", 32'(m_valid),     32'd0);
        chk("mr_r_en",    32'(r_en),        32'd0);
        chk("mr_busy",    32'(busy),        32'd0);
        chk("mr_m_data",  32'(m_data),      32'd0);
        chk("mr_pop",     32'(pop_count),   32'd0);
        chk("mr_stall",   32'(stall_count), 32'd0);
        @(posedge r_clk);
        #1;
        r_rst = 1'b1;
        exp_q = fifo_q;   // resume from the current FIFO head
        chk("mr_head_remaining", 32'(fifo_q.size()), 32'd6);
        drain(40);
        chk("mr_pop_after", 32'(pop_count),   STATS ? 32'd6 : 32'd0);
        chk("mr_stall_after", 32'(stall_count), 32'd0);

        chk("no_underflow", 32'(underflow_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain stage sitting directly downstream of the async FIFO's read port, in the `r_clk` domain. Pops words from the FIFO whenever it is non-empty and buffer space allows, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents them on a valid/ready stream.
- Preserves word order.
- Sustains one word per cycle under continuous `m_ready`.

## Interface
Parameters:
- `DATASIZE`, 8, width of FIFO word and stream data.

Ports:
- `r_clk`  in  1  read-domain clock; all logic on its rising edge.
- `r_rst`  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronous to `r_clk` upstream.
- `r_empty`  in  1  FIFO empty flag, `r_clk` domain.
- `r_en`  out  1  FIFO pop request; one word popped per cycle high.
- `r_data`  in  `DATASIZE`  FIFO read data; valid in the cycle after `r_en`.
- `flush`  in  1  synchronous discard of all buffered and in-flight words.
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  consumer accepts; transfer when `m_valid & m_ready`.
- `m_data`  out  `DATASIZE`  stream data (head of skid buffer).
- `busy`  out  1  buffer non-empty or a read is in flight.
- `pop_count`  out  16  words popped (stats build only).
- `stall_count`  out  16  backpressure cycles (stats build only).

## Operation
Skid buffer:
- `occ` ∈ {0,1,2}: states EMPTY, ONE, TWO.
- `inflight` ∈ {0,1}: registered copy of last `r_en`.

Pop:
- `r_en = !r_empty && !flush && (occ + inflight < 2 || (m_valid && m_ready))`.
- Never pops when `r_empty` = 1, so the FIFO cannot underflow.
- Reachable (`occ`, `inflight`) pairs are bounded to (2,0), (1,1) and below; the buffer never overflows.

Capture and transfer:
- When `inflight` = 1, `r_data` is written to the tail at the cycle's edge.
- Transfer removes the head.
- Simultaneous capture and transfer: `occ` unchanged, head advances, order kept.
- Capture into EMPTY with no transfer makes the new word the head.

Stream outputs:
- `m_valid = (occ != 0) && !flush`.
- `m_data` = head entry; stable while `m_valid && !m_ready`.
- `busy = (occ != 0) || inflight`.

Flush (cycle with `flush` = 1):
- `r_en` = 0, `m_valid` = 0, no transfer.
- Next state: `occ` = 0, `inflight` = 0.
- A word arriving that cycle is dropped.
- Words already popped from the FIFO are lost by design.

Reset (`r_rst` = 0, any time, including mid-transfer):
- `r_en` = 0, `m_valid` = 0, `m_data` = 0, `busy` = 0.
- `occ` = 0, `inflight` = 0, both counters 0, buffer contents cleared to 0.

## Timing
- `r_en` is combinational from `r_empty`, `flush`, `m_ready` and state; no other comb paths to outputs except `m_valid` ← `flush`.
- First-word latency: `r_empty` falls in cycle t with EMPTY state → `r_en` = 1 in t → `r_data` valid t+1 → `m_valid` = 1, `m_data` correct in t+2.
- Throughput: 1 word/cycle with `m_ready` held high and FIFO non-empty.
- Backpressure: `m_ready` = 0 from cycle t → at most 2 words held, `r_en` = 0 once `occ + inflight` = 2.
- Resume: `m_ready` rising in cycle u → transfer in u; with `occ` = 2, `r_en` may also assert in u.

## Configuration
- Macro: `FIFO_RD_STATS_EN`.
- Defined:
  - `pop_count` increments each cycle `r_en` = 1, wrapping modulo 2^16.
  - `stall_count` increments each cycle `m_valid && !m_ready`, saturating at 16'hFFFF.
  - Both counters cleared by reset only, not by `flush`.
- Undefined: both ports tied to 16'h0000 and no counter flops are built; all other behaviour identical.

## Test plan
- Reset, then FIFO preloaded with 0x01..0x10, `m_ready` = 1 → first `m_valid` 2 cycles after `r_empty` falls; 16 consecutive transfers 0x01..0x10 in order; `pop_count` = 16.
- `m_ready` = 0 for 10 cycles with FIFO holding 8 words → exactly 2 pops, `m_data` held at first word, `stall_count` = 10 less the 2 fill cycles; release → remaining 8 words in order.
- `m_ready` toggling 1/0 each cycle over 32 words → no loss or duplication; `r_empty` = 1 never coincides with `r_en` = 1.
- `flush` pulsed with `occ` = 2 and `inflight` = 0 → next cycle `m_valid` = 0, `busy` = 0; the following word popped appears next, not the flushed ones.
- `r_rst` driven low mid-stream with `occ` = 1 → immediately `m_valid` = 0, `r_en` = 0, counters 0; after release, normal drain resumes from the current FIFO head.
- Build without `FIFO_RD_STATS_EN` → `pop_count` and `stall_count` are 0 throughout the first scenario; data behaviour identical.
